// File: rtl/scanchain_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : scanchain_packet_assembler
//  Description : Assembles framed UART bytes into scan-chain write requests.
//                Header 0x01 introduces a 2-byte address and a payload of
//                ceil(PAYLOAD_BITS/8) bytes, both little-endian. Header 0x02
//                issues a reset command. Bad headers and inter-byte timeouts
//                bump a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module scanchain_packet_assembler #(
    parameter int ADDR_BITS      = 12,
    parameter int PAYLOAD_BITS   = 169,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [ADDR_BITS-1:0]    write_addr,
    output logic [PAYLOAD_BITS-1:0] write_payload,
    output logic                    write_reset,
    output logic [7:0]              err_count
);

    localparam int c_PAYLOAD_BYTES = (PAYLOAD_BITS + 7) / 8;
    localparam int c_CNT_W         = $clog2(c_PAYLOAD_BYTES + 1);
    localparam int c_TO_W          = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_PAY_LAST  = c_CNT_W'(c_PAYLOAD_BYTES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_wvalid;
    logic                    r_wreset;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [PAYLOAD_BITS-1:0] r_payload;
    logic [7:0]              r_err;
    logic [c_CNT_W-1:0]      r_byte_cnt;
    logic [c_TO_W-1:0]       r_to_cnt;

    logic                    w_accept;
    logic [7:0]              w_err_inc;

    // Byte handshake and saturating error increment
    always_comb begin
        w_accept  = in_valid & r_in_ready;
        w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
    end

    // Framing state machine with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_wvalid   <= 1'b0;
            r_wreset   <= 1'b0;
            r_addr     <= '0;
            r_payload  <= '0;
            r_err      <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_data == 8'h01) begin
                            r_state    <= S_ADDR;
                            r_byte_cnt <= '0;
                            r_to_cnt   <= '0;
                            r_addr     <= '0;
                            r_payload  <= '0;
                        end else if (in_data == 8'h02) begin
                            r_state    <= S_OUT;
                            r_addr     <= '0;
                            r_payload  <= '0;
                            r_wreset   <= 1'b1;
                            r_wvalid   <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_err <= w_err_inc;
                        end
                    end
                end
                S_ADDR, S_PAYLOAD: begin
                    if (w_accept) begin
                        r_to_cnt <= '0;
                        // Drop the byte into its little-endian lane; bits beyond the field width fall away
                        if (r_state == S_ADDR) begin
                            for (int i = 0; i < ADDR_BITS; i++)
                                if ((i / 8) == int'(r_byte_cnt)) r_addr[i] <= in_data[i[2:0]];
                            if (r_byte_cnt == c_ADDR_LAST) begin
                                r_state    <= S_PAYLOAD;
                                r_byte_cnt <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                            end
                        end else begin
                            for (int i = 0; i < PAYLOAD_BITS; i++)
                                if ((i / 8) == int'(r_byte_cnt)) r_payload[i] <= in_data[i[2:0]];
                            if (r_byte_cnt == c_PAY_LAST) begin
                                r_state    <= S_OUT;
                                r_byte_cnt <= '0;
                                r_wvalid   <= 1'b1;
                                r_wreset   <= 1'b0;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                            end
                        end
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // Sender went quiet: abandon the partial packet
                        r_state    <= S_IDLE;
                        r_byte_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_addr     <= '0;
                        r_payload  <= '0;
                        r_err      <= w_err_inc;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                S_OUT: begin
                    if (write_ready) begin
                        r_state    <= S_IDLE;
                        r_wvalid   <= 1'b0;
                        r_wreset   <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wvalid   <= 1'b0;
                    r_wreset   <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        in_ready      = r_in_ready;
        write_valid   = r_wvalid;
        write_reset   = r_wreset;
        write_addr    = r_addr;
        write_payload = r_payload;
        err_count     = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_scanchain_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scanchain_packet_assembler
//  Description : Scoreboard bench: the stimulus side pushes expected write
//                requests, a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scanchain_packet_assembler;

    localparam int AB = 12;
    localparam int PB = 169;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          write_valid;
    logic          write_ready;
    logic [AB-1:0] write_addr;
    logic [PB-1:0] write_payload;
    logic          write_reset;
    logic [7:0]    err_count;

    scanchain_packet_assembler #(
        .ADDR_BITS      (AB),
        .PAYLOAD_BITS   (PB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_addr    (write_addr),
        .write_payload (write_payload),
        .write_reset   (write_reset),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0] a;
        logic [PB-1:0] p;
        logic          r;
        int            n;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   seen = 0;
    int   ncyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    int   ready_mode = 0;   // 0 random, 1 forced low, 2 forced high

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop on the first cycle a request shows, then hold it to that value
    always @(negedge clk) begin
        ncyc++;
        if (write_valid === 1'b1) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    chk("unexpected_write_valid", 256'(write_valid), 256'(0));
                end else begin
                    cur  = q.pop_front();
                    seen = 1;
                    chk("write_latency", 256'(ncyc), 256'(cur.n));
                end
            end
            if (seen) begin
                chk("write_addr", 256'(write_addr), 256'(cur.a));
                chk("write_payload", 256'(write_payload), 256'(cur.p));
                chk("write_reset", 256'(write_reset), 256'(cur.r));
                chk("in_ready_in_out", 256'(in_ready), 256'(0));
            end
            if (write_ready) seen = 0;
        end
    end

    // Downstream ready driver
    initial begin
        write_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       write_ready = 1'b0;
                2:       write_ready = 1'b1;
                default: write_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte; returns the negedge index at which acceptance was seen
    task automatic send_byte(input logic [7:0] b, output int acc_n);
        int budget;
        budget   = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (in_ready) break;
            budget++;
            if (budget > 400) begin
                chk("in_ready_wait_expired", 256'(0), 256'(1));
                break;
            end
        end
        acc_n = ncyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap_send(input logic [7:0] b, input bit rnd, output int acc_n);
        if (rnd) idle($urandom_range(0, 3));
        send_byte(b, acc_n);
    endtask

    // Full 0x01 packet; g1 >= 0 inserts that many idle cycles after the header
    task automatic send_packet(input logic [AB-1:0] a, input logic [3:0] junk,
                               input bit rnd, input int g1);
        logic [175:0] full;
        logic [7:0]   b;
        exp_t         e;
        int           n;
        full = '0;
        gap_send(8'h01, rnd, n);
        if (g1 >= 0) idle(g1);
        if (g1 >= 0) send_byte(a[7:0], n);
        else         gap_send(a[7:0], rnd, n);
        gap_send({junk, a[11:8]}, rnd, n);
        for (int k = 0; k < 22; k++) begin
            b = rnd ? 8'($urandom) : 8'(k);
            full[8*k +: 8] = b;
            gap_send(b, rnd, n);
        end
        e.a = a;
        e.p = full[PB-1:0];
        e.r = 1'b0;
        e.n = n + 1;
        q.push_back(e);
    endtask

    task automatic send_cmd_reset();
        exp_t e;
        int   n;
        send_byte(8'h02, n);
        e.a = '0;
        e.p = '0;
        e.r = 1'b1;
        e.n = n + 1;
        q.push_back(e);
    endtask

    task automatic send_bad();
        logic [7:0] b;
        int         n;
        do b = 8'($urandom); while (b == 8'h01 || b == 8'h02);
        send_byte(b, n);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q.size() != 0 || write_valid) && budget < 500) begin
            idle(1);
            budget++;
        end
        chk("drain_queue_empty", 256'(q.size()), 256'(0));
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        chk({tag, "_write_valid"}, 256'(write_valid), 256'(0));
        chk({tag, "_write_reset"}, 256'(write_reset), 256'(0));
        chk({tag, "_write_addr"}, 256'(write_addr), 256'(0));
        chk({tag, "_write_payload"}, 256'(write_payload), 256'(0));
        chk({tag, "_err_count"}, 256'(err_count), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("por");

        // Directed packet: address 0x234, payload byte k = k, bit 168 set
        send_packet(12'h234, 4'hF, 1'b0, -1);
        drain();

        // Reset command
        send_cmd_reset();
        drain();

        // Downstream stalls 50 cycles while upstream keeps offering a header
        ready_mode = 1;
        idle(1);
        send_packet(12'h5A5, 4'h3, 1'b1, -1);
        chk("hold_write_valid_up", 256'(write_valid), 256'(1));
        in_data  = 8'h01;
        in_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            #1;
            chk("hold_in_ready_low", 256'(in_ready), 256'(0));
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        write_ready = 1'b1;
        ready_mode  = 2;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("release_write_valid", 256'(write_valid), 256'(0));
        chk("release_write_reset", 256'(write_reset), 256'(0));
        chk("release_in_ready", 256'(in_ready), 256'(1));
        idle(1);
        ready_mode = 0;
        // A still-idle block must treat 0x02 as a command, not an address byte
        send_cmd_reset();
        drain();

        // Bad header, then a partial packet left to time out
        send_bad();
        send_byte(8'h01, n);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 8'h40), n);
        idle(TO + 5);
        exp_err++;
        chk("timeout_err_count", 256'(err_count), 256'(exp_err));
        chk("timeout_err_is_2", 256'(err_count), 256'(2));
        send_packet(12'h9C3, 4'h0, 1'b1, -1);
        drain();

        // Byte arriving on the last timeout cycle keeps the packet alive
        send_packet(12'h0F1, 4'hA, 1'b0, TO - 1);
        drain();
        chk("late_byte_no_err", 256'(err_count), 256'(exp_err));

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: send_packet(12'($urandom), 4'($urandom), 1'b1, -1);
                1: send_cmd_reset();
                2: send_bad();
                default: begin
                    int nb;
                    nb = $urandom_range(0, 23);
                    gap_send(8'h01, 1'b1, n);
                    for (int k = 0; k < nb; k++) gap_send(8'($urandom), 1'b1, n);
                    idle(TO + 5);
                    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                end
            endcase
            chk("rand_err_count", 256'(err_count), 256'(exp_err));
        end
        drain();

        // Reset in the middle of a payload discards it silently
        send_byte(8'h01, n);
        send_byte(8'h77, n);
        send_byte(8'h01, n);
        for (int k = 0; k < 11; k++) send_byte(8'($urandom), n);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 0;
        check_reset_state("midpkt_reset");
        send_packet(12'hABC, 4'h5, 1'b1, -1);
        drain();

        // Error counter saturation
        for (int k = 0; k < 300; k++) send_bad();
        chk("err_saturated", 256'(err_count), 256'(255));
        send_packet(12'h123, 4'h6, 1'b1, -1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
